countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
Front-panel sequencer for the countdown timer datapath (counter_down) in the electric-clock design. It turns debounced key events into counter_down's control inputs: one-hot cnt_inc/cnt_dec field pulses, start_flag, reset_flag and the cnt_down run level. It also drives the edit-field blink and the timeout alarm. It sits between the key debouncers and counter_down. Its outputs connect 1:1 to counter_down's inputs of the same name.

Parameters:
HOLD_CYC, 25_000_000, cycles a key is held before auto-repeat starts (0.5 s at 50 MHz)
REPEAT_CYC, 5_000_000, auto-repeat pulse period in cycles
BLINK_CYC, 12_500_000, half-period of the blink toggle in SET
ALARM_CYC, 250_000_000, alarm duration in cycles

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
key_mode_p  in  1  single-cycle pulse: enter SET / advance field / exit SET
key_start_p  in  1  single-cycle pulse: start / pause / resume
key_reset_p  in  1  single-cycle pulse: abort and clear the counter
key_up  in  1  debounced level, increment key
key_down  in  1  debounced level, decrement key
cnt_zero  in  1  level from datapath, counter value == 0
cnt_inc  out  3  one-hot 1-cycle increment pulse; bit i = field i
cnt_dec  out  3  one-hot 1-cycle decrement pulse
cnt_down  out  1  run level; counter decrements while high
start_flag  out  1  1-cycle pulse when counting starts from IDLE
reset_flag  out  1  1-cycle pulse that clears the counter
sel  out  2  field under edit (0..2); 0 outside SET
blink  out  1  blink phase for the selected field; 0 outside SET
alarm  out  1  high in DONE

Behaviour:
- All outputs are registered. Reset value of every output is 0; state is IDLE; all timers are 0.
- Latency: a key event at cycle n produces its output pulse or level change at cycle n+1.
- States:
  - IDLE: cnt_down=0.
    - key_mode_p -> SET with sel=0.
    - key_start_p with cnt_zero=0 -> RUN, with start_flag=1 for one cycle.
    - key_start_p with cnt_zero=1 is ignored.
  - SET: cnt_down=0. key_mode_p advances sel 0->1->2; from sel=2 it returns to IDLE and sel=0. key_start_p is ignored.
  - RUN: cnt_down=1.
    - cnt_zero=1 -> DONE.
    - key_start_p -> PAUSE.
    - cnt_zero and key_start_p in the same cycle: DONE wins.
  - PAUSE: cnt_down=0. key_start_p -> RUN (no start_flag on resume).
  - DONE: cnt_down=0, alarm=1. Returns to IDLE after ALARM_CYC cycles, or on any key pulse or key_up/key_down rising edge. That key event is consumed and takes no other action.
- key_reset_p in any state has highest priority:
  - reset_flag=1 for one cycle.
  - -> IDLE; sel, blink, alarm and all timers are cleared.
  - Any simultaneous key event is dropped.
- Edit pulses are generated only in SET; cnt_inc and cnt_dec are 3'b000 in every other state.
- Auto-repeat, applied to up and down independently:
  - A rising edge emits one pulse on field sel.
  - If the key stays high for HOLD_CYC cycles, a pulse follows, then one every REPEAT_CYC cycles while held.
  - Release clears the repeat timer.
- key_up and key_down both high: no pulses, and both timers are held at 0. cnt_inc and cnt_dec are never nonzero in the same cycle.
- Changing sel while a key is held: the repeat continues on the new field; the timer is not reset.
- The blink counter runs only in SET. blink toggles every BLINK_CYC cycles. Entering SET or changing sel restarts it with blink=1.
- Timer widths are $clog2(param+1). Timers saturate and never wrap.

Decomposition:
- Package countdown_pkg: state enum (IDLE, SET, RUN, PAUSE, DONE); field index constants FLD_0..FLD_2; field count 3.
- Sub-module key_repeat (params HOLD_CYC, REPEAT_CYC; in Clk, Reset_n, en, key; out pulse), instantiated once each for up and down.
  - en is low outside SET or when both keys are held.
  - en low clears the timer and the edge history.

Test Plan:
Test parameter overrides: HOLD_CYC=8, REPEAT_CYC=4, BLINK_CYC=4, ALARM_CYC=20.
- Reset_n low mid-RUN -> next edge has cnt_down=0, state IDLE, all outputs 0; after release, key_start_p with cnt_zero=0 -> start_flag=1 for 1 cycle at n+1, cnt_down=1 from n+1.
- key_mode_p, then hold key_up for 20 cycles -> cnt_inc=3'b001 pulses at cycles 1, 9, 13, 17 after press edge; key_mode_p then key_down edge -> cnt_dec=3'b010 once.
- In SET, key_up and key_down both high for 20 cycles -> cnt_inc=cnt_dec=0 throughout; key_mode_p x3 from IDLE -> sel 0,1,2, then IDLE with sel=0.
- RUN, key_start_p -> PAUSE, cnt_down=0; key_start_p -> RUN, cnt_down=1, start_flag stays 0.
- RUN, cnt_zero=1 and key_start_p in the same cycle -> DONE, alarm=1 for exactly 20 cycles, then IDLE.
- key_reset_p in PAUSE together with key_start_p -> reset_flag=1 one cycle, IDLE, cnt_down stays 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown front-panel sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         NUM_FIELDS = 3;
    localparam logic [1:0] FLD_0      = 2'd0;
    localparam logic [1:0] FLD_1      = 2'd1;
    localparam logic [1:0] FLD_2      = 2'd2;

    // One-hot strobe for the field currently being edited.
    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [1:0] fld);
        logic [NUM_FIELDS-1:0] one;
        one = 3'b001;
        return one << fld;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge + auto-repeat pulse generator for one held key.
// Latency: pulse is combinational from this cycle's key and registered history; the parent registers it.
// Backpressure: none; en low clears the hold/repeat timers and the edge history.
module key_repeat #(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic en,
    input  logic key,
    output logic pulse
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(REPEAT_CYC + 1);

    logic          key_q, key_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;

    // Hold timer counts up to HOLD_CYC and sticks there; only then does the repeat timer run.
    always_comb begin
        key_d  = en & key;
        hold_d = hold_q;
        rep_d  = rep_q;
        pulse  = 1'b0;
        if (!en || !key) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (!key_q) begin
            pulse  = 1'b1;
            hold_d = '0;
            rep_d  = '0;
        end else if (hold_q != HW'(HOLD_CYC)) begin
            hold_d = hold_q + HW'(1);
            if (hold_d == HW'(HOLD_CYC)) begin
                pulse = 1'b1;
            end
        end else if (rep_q == RW'(REPEAT_CYC - 1)) begin
            pulse = 1'b1;
            rep_d = '0;
        end else begin
            rep_d = rep_q + RW'(1);
        end
    end

    // Edge history and timers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_q  <= 1'b0;
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            key_q  <= key_d;
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Front-panel sequencer: key events -> counter_down controls, edit blink and alarm.
// Latency: every output is registered; a key event at cycle n shows at cycle n+1.
// Backpressure: none; key_reset_p overrides everything, unused key events are dropped.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int BLINK_CYC  = 12_500_000,
    parameter int ALARM_CYC  = 250_000_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       key_mode_p,
    input  logic       key_start_p,
    input  logic       key_reset_p,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       cnt_zero,
    output logic [2:0] cnt_inc,
    output logic [2:0] cnt_dec,
    output logic       cnt_down,
    output logic       start_flag,
    output logic       reset_flag,
    output logic [1:0] sel,
    output logic       blink,
    output logic       alarm
);

    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int AW = $clog2(ALARM_CYC + 1);

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          up_q, dn_q;
    logic [2:0]    cnt_inc_q, cnt_inc_d, cnt_dec_q, cnt_dec_d;
    logic          cnt_down_q, cnt_down_d, start_flag_q, start_flag_d;
    logic          reset_flag_q, reset_flag_d, alarm_q, alarm_d;

    logic edit_en, up_pulse, dn_pulse, up_rise, dn_rise;

    // Repeat generators only run while editing with exactly one key held; a reset key clears them.
    assign edit_en = (state_q == SET) && !(key_up && key_down) && !key_reset_p;
    assign up_rise = key_up & ~up_q;
    assign dn_rise = key_down & ~dn_q;

    key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_up (
        .Clk(Clk), .Reset_n(Reset_n), .en(edit_en), .key(key_up), .pulse(up_pulse)
    );

    key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_dn (
        .Clk(Clk), .Reset_n(Reset_n), .en(edit_en), .key(key_down), .pulse(dn_pulse)
    );

    // Next state, field select, blink/alarm timers and the registered output values.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        alarm_cnt_d  = '0;
        cnt_inc_d    = 3'b000;
        cnt_dec_d    = 3'b000;
        start_flag_d = 1'b0;
        reset_flag_d = 1'b0;
        if (key_reset_p) begin
            state_d      = IDLE;
            sel_d        = FLD_0;
            blink_d      = 1'b0;
            blink_cnt_d  = '0;
            reset_flag_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_mode_p) begin
                        state_d     = SET;
                        sel_d       = FLD_0;
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else if (key_start_p && !cnt_zero) begin
                        state_d      = RUN;
                        start_flag_d = 1'b1;
                    end
                end
                SET: begin
                    // Pulses land on the field selected when the key event happened.
                    if (up_pulse) cnt_inc_d = field_onehot(sel_q);
                    if (dn_pulse) cnt_dec_d = field_onehot(sel_q);
                    if (key_mode_p) begin
                        blink_cnt_d = '0;
                        if (sel_q == FLD_2) begin
                            state_d = IDLE;
                            sel_d   = FLD_0;
                            blink_d = 1'b0;
                        end else begin
                            sel_d   = sel_q + 2'd1;
                            blink_d = 1'b1;
                        end
                    end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
                RUN: begin
                    if (cnt_zero) begin
                        state_d = DONE;
                    end else if (key_start_p) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (key_start_p) state_d = RUN;
                end
                DONE: begin
                    // Any key just acknowledges the alarm.
                    if (key_mode_p || key_start_p || up_rise || dn_rise) begin
                        state_d = IDLE;
                    end else if (alarm_cnt_q == AW'(ALARM_CYC - 1)) begin
                        state_d = IDLE;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + AW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        cnt_down_d = (state_d == RUN);
        alarm_d    = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            sel_q        <= FLD_0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
            alarm_cnt_q  <= '0;
            up_q         <= 1'b0;
            dn_q         <= 1'b0;
            cnt_inc_q    <= 3'b000;
            cnt_dec_q    <= 3'b000;
            cnt_down_q   <= 1'b0;
            start_flag_q <= 1'b0;
            reset_flag_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            alarm_cnt_q  <= alarm_cnt_d;
            up_q         <= key_up;
            dn_q         <= key_down;
            cnt_inc_q    <= cnt_inc_d;
            cnt_dec_q    <= cnt_dec_d;
            cnt_down_q   <= cnt_down_d;
            start_flag_q <= start_flag_d;
            reset_flag_q <= reset_flag_d;
            alarm_q      <= alarm_d;
        end
    end

    assign cnt_inc    = cnt_inc_q;
    assign cnt_dec    = cnt_dec_q;
    assign cnt_down   = cnt_down_q;
    assign start_flag = start_flag_q;
    assign reset_flag = reset_flag_q;
    assign sel        = sel_q;
    assign blink      = blink_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl against a behavioural panel model.
// Latency: expected values are queued at the input-drive point, compared after the next edge.
// Backpressure: n/a.
module tb_countdown_ctrl;

    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int BLINK = 4;
    localparam int ALARM = 20;

    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       key_mode_p = 1'b0, key_start_p = 1'b0, key_reset_p = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, cnt_zero = 1'b0;
    logic [2:0] cnt_inc, cnt_dec;
    logic       cnt_down, start_flag, reset_flag, blink, alarm;
    logic [1:0] sel;

    typedef struct packed {
        logic [2:0] inc;
        logic [2:0] dec;
        logic       down;
        logic       start;
        logic       rflag;
        logic [1:0] sel;
        logic       blink;
        logic       alarm;
    } out_t;

    out_t exp_q[$];
    int   checks = 0, failures = 0;
    int   inc_pulses = 0, dec_pulses = 0, alarm_cycles = 0, cyc_no = 0;

    // Model state: panel mode, edited field, time in field, time in alarm, key hold ages.
    int m_state, m_sel, m_field_t, m_done_t, m_up_held, m_dn_held;
    bit m_up_prev, m_dn_prev;

    countdown_ctrl #(
        .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .BLINK_CYC(BLINK), .ALARM_CYC(ALARM)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .key_mode_p(key_mode_p), .key_start_p(key_start_p), .key_reset_p(key_reset_p),
        .key_up(key_up), .key_down(key_down), .cnt_zero(cnt_zero),
        .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .cnt_down(cnt_down),
        .start_flag(start_flag), .reset_flag(reset_flag),
        .sel(sel), .blink(blink), .alarm(alarm)
    );

    always #5 Clk = ~Clk;

    // A key held for h cycles since its press fires at 0, HOLD, HOLD+REP, HOLD+2*REP, ...
    function automatic bit rep_fire(input int h);
        return (h == 0) || (h == HOLD) || (h > HOLD && ((h - HOLD) % REP) == 0);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_sel = 0; m_field_t = 0; m_done_t = 0;
        m_up_held = -1; m_dn_held = -1; m_up_prev = 0; m_dn_prev = 0;
    endtask

    task automatic model_step(output out_t e);
        bit up, dn, en, up_p, dn_p, up_rise, dn_rise, any_key;
        logic [2:0] one;
        one = 3'b001;
        up = key_up; dn = key_down;
        en = (m_state == M_SET) && !(up && dn) && !key_reset_p;
        up_p = 0; dn_p = 0;
        if (en && up) begin m_up_held++; up_p = rep_fire(m_up_held); end else m_up_held = -1;
        if (en && dn) begin m_dn_held++; dn_p = rep_fire(m_dn_held); end else m_dn_held = -1;
        up_rise = up && !m_up_prev;
        dn_rise = dn && !m_dn_prev;
        any_key = key_mode_p || key_start_p || up_rise || dn_rise;
        e = '0;
        if (key_reset_p) begin
            m_state = M_IDLE; m_sel = 0; e.rflag = 1'b1;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (key_mode_p) begin m_state = M_SET; m_sel = 0; m_field_t = 0; end
                    else if (key_start_p && !cnt_zero) begin m_state = M_RUN; e.start = 1'b1; end
                end
                M_SET: begin
                    if (up_p) e.inc = one << m_sel;
                    if (dn_p) e.dec = one << m_sel;
                    if (key_mode_p) begin
                        if (m_sel == 2) begin m_state = M_IDLE; m_sel = 0; end
                        else begin m_sel++; m_field_t = 0; end
                    end else m_field_t++;
                end
                M_RUN: begin
                    if (cnt_zero) begin m_state = M_DONE; m_done_t = 0; end
                    else if (key_start_p) m_state = M_PAUSE;
                end
                M_PAUSE: if (key_start_p) m_state = M_RUN;
                M_DONE: begin
                    if (any_key) m_state = M_IDLE;
                    else begin
                        m_done_t++;
                        if (m_done_t >= ALARM) m_state = M_IDLE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
        m_up_prev = up; m_dn_prev = dn;
        e.sel   = 2'(m_sel);
        e.down  = (m_state == M_RUN);
        e.alarm = (m_state == M_DONE);
        e.blink = (m_state == M_SET) && (((m_field_t / BLINK) % 2) == 0);
    endtask

    task automatic cyc(input bit mode, input bit st, input bit rp,
                       input bit up, input bit dn, input bit zero);
        out_t e;
        @(negedge Clk);
        Reset_n = 1'b1;
        key_mode_p = mode; key_start_p = st; key_reset_p = rp;
        key_up = up; key_down = dn; cnt_zero = zero;
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Reset_n = 1'b0;
            key_mode_p = 0; key_start_p = 0; key_reset_p = 0;
            key_up = 0; key_down = 0; cnt_zero = 0;
            model_reset();
            exp_q.push_back('0);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: one expected output word per clock, compared just after the edge.
    initial begin
        out_t e, a;
        forever begin
            @(posedge Clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{inc: cnt_inc, dec: cnt_dec, down: cnt_down, start: start_flag,
                      rflag: reset_flag, sel: sel, blink: blink, alarm: alarm};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got inc=%b dec=%b down=%b start=%b rst=%b sel=%0d blink=%b alarm=%b, required inc=%b dec=%b down=%b start=%b rst=%b sel=%0d blink=%b alarm=%b",
                             cyc_no, a.inc, a.dec, a.down, a.start, a.rflag, a.sel, a.blink, a.alarm,
                             e.inc, e.dec, e.down, e.start, e.rflag, e.sel, e.blink, e.alarm);
                end
            end
            if (cnt_inc != 3'b000) inc_pulses++;
            if (cnt_dec != 3'b000) dec_pulses++;
            if (alarm) alarm_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bit r_up, r_dn, r_zero;
        model_reset();
        apply_reset(3);
        idle(2);

        // Async reset in the middle of a run, then a clean start.
        cyc(0, 1, 0, 0, 0, 0);
        idle(3);
        apply_reset(2);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0);
        idle(1);

        // Auto-repeat on field 0, then a single decrement on field 1.
        cyc(1, 0, 0, 0, 0, 0);
        snap = inc_pulses;
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        check_int("hold_up_pulses", inc_pulses - snap, 4);
        cyc(1, 0, 0, 0, 0, 0);
        snap = dec_pulses;
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);
        check_int("down_edge_pulses", dec_pulses - snap, 1);

        // Both keys held: no edit pulses.
        snap = inc_pulses + dec_pulses;
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 1, 0);
        idle(2);
        check_int("both_keys_pulses", inc_pulses + dec_pulses - snap, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);

        // Walk through all fields from IDLE and back.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            idle(2);
        end

        // Pause and resume.
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);

        // Zero and start together: alarm wins, lasts ALARM cycles.
        snap = alarm_cycles;
        cyc(0, 1, 0, 0, 0, 1);
        idle(25);
        check_int("alarm_cycles", alarm_cycles - snap, ALARM);
        cyc(0, 1, 0, 0, 0, 1);
        idle(2);

        // Reset key in PAUSE alongside start.
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 1, 0, 0, 0);
        idle(2);

        // Alarm acknowledged by an up-key edge.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        idle(3);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);

        // Randomized panel activity.
        r_up = 0; r_dn = 0; r_zero = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(14) == 0) r_up = ~r_up;
            if ($urandom_range(14) == 0) r_dn = ~r_dn;
            if ($urandom_range(24) == 0) r_zero = ~r_zero;
            cyc($urandom_range(11) == 0, $urandom_range(9) == 0, $urandom_range(79) == 0,
                r_up, r_dn, r_zero);
        end
        idle(3);
        check_int("scoreboard_drained", exp_q.size(), 1);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
